ifetch_axi_master: RTL

AXI4-Lite read initiator that fetches 32-bit instructions for the RV32I core from the instruction memory's AR/R channels. It accepts a byte-addressed PC from the fetch stage and converts it to a word index. It drives one outstanding read at a time and returns the instruction, its PC and a status code through a one-entry output buffer with a valid/ready handshake. It sits between the core's fetch stage and the instruction-memory AXI read port.

---
 rtl/ifetch_axi_master.sv | 104 ++++++++++
 1 files changed

// File: rtl/ifetch_axi_master.sv
// AXI4-Lite instruction fetch initiator: one outstanding read, one-entry result buffer.
// A timed-out read leaves its R beat in flight; drain_pending swallows that beat.
module ifetch_axi_master #(
  parameter int AXI_AWIDTH     = 4,
  parameter int AXI_DWIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  AXI_ACLK,
  input  logic                  AXI_ARESET,
  input  logic                  FETCH_VALID,
  input  logic [31:0]           FETCH_PC,
  output logic                  FETCH_READY,
  output logic                  INSTR_VALID,
  output logic [31:0]           INSTR_DATA,
  output logic [31:0]           INSTR_PC,
  output logic [1:0]            INSTR_ERR,
  input  logic                  INSTR_READY,
  output logic [AXI_AWIDTH-1:0] AXI_ARADDR,
  output logic                  AXI_ARVALID,
  input  logic                  AXI_ARREADY,
  input  logic [AXI_DWIDTH-1:0] AXI_RDATA,
  input  logic [1:0]            AXI_RRESP,
  input  logic                  AXI_RVALID,
  output logic                  AXI_RREADY
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          CW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t        state;
  logic          obuf_valid;
  logic          drain_pending;
  logic [CW-1:0] cnt;
  logic          addr_fault;

  assign FETCH_READY = (state == IDLE) && !obuf_valid && !drain_pending;
  assign INSTR_VALID = obuf_valid;
  assign addr_fault  = (FETCH_PC[1:0] != 2'b00) || (FETCH_PC[31:AXI_AWIDTH+2] != '0);

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      state         <= IDLE;
      obuf_valid    <= 1'b0;
      drain_pending <= 1'b0;
      cnt           <= '0;
      AXI_ARVALID   <= 1'b0;
      AXI_RREADY    <= 1'b0;
      AXI_ARADDR    <= '0;
      INSTR_DATA    <= NOP;
      INSTR_PC      <= '0;
      INSTR_ERR     <= 2'b00;
    end else begin
      if (obuf_valid && INSTR_READY) obuf_valid <= 1'b0;
      case (state)
        IDLE: begin
          // RREADY stays high from the timed-out read until its stale beat lands
          if (drain_pending && AXI_RVALID) begin
            drain_pending <= 1'b0;
            AXI_RREADY    <= 1'b0;
          end
          if (FETCH_VALID && FETCH_READY) begin
            INSTR_PC <= FETCH_PC;
            if (addr_fault) begin
              obuf_valid <= 1'b1;
              INSTR_DATA <= NOP;
              INSTR_ERR  <= 2'b01;
            end else begin
              AXI_ARADDR  <= FETCH_PC[AXI_AWIDTH+1:2];
              AXI_ARVALID <= 1'b1;
              AXI_RREADY  <= 1'b1;
              state       <= ADDR;
            end
          end
        end
        ADDR: begin
          // any R beat seen here predates our AR and is dropped
          if (AXI_ARREADY) begin
            AXI_ARVALID <= 1'b0;
            cnt         <= '0;
            state       <= DATA;
          end
        end
        DATA: begin
          cnt <= cnt + 1'b1;
          if (AXI_RVALID) begin
            obuf_valid <= 1'b1;
            INSTR_DATA <= (AXI_RRESP == 2'b00) ? AXI_RDATA[31:0] : NOP;
            INSTR_ERR  <= (AXI_RRESP == 2'b00) ? 2'b00 : 2'b10;
            AXI_RREADY <= 1'b0;
            state      <= IDLE;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            obuf_valid    <= 1'b1;
            INSTR_DATA    <= NOP;
            INSTR_ERR     <= 2'b11;
            drain_pending <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
